multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM that steps the CPU datapath through FETCH/DECODE/EXEC/MEM/WB, one phase at a time.
- Shares one memory port between instruction fetch and data load/store over a req/ack handshake.
- Consumes the one-hot instruction-class flags from the instruction decoder.
- Drives the write enables and mux selects for the PC, IR, MDR and register file.

---
 rtl/seq_pkg.sv | 36 +++
 rtl/ack_watchdog.sv | 38 +++
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding, select constants and helpers for the
//            multi-cycle control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic MEM_SEL_INSTR = 1'b0;
    localparam logic MEM_SEL_DATA  = 1'b1;
    localparam logic WB_SRC_ALU    = 1'b0;
    localparam logic WB_SRC_MEM    = 1'b1;
    localparam logic PC_SEL_SEQ    = 1'b0;
    localparam logic PC_SEL_JUMP   = 1'b1;
    localparam logic DST_RD        = 1'b0;
    localparam logic DST_RT        = 1'b1;

    function automatic logic is_one_hot(input logic [4:0] flags);
        return (flags != 5'd0) && ((flags & (flags - 5'd1)) == 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ack_watchdog.sv
// ============================================================================
// Module   : ack_watchdog
// Purpose  : Counts memory-request cycles without acknowledge and flags a
//            timeout on the cycle the wait count would reach ACK_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ack_watchdog #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic clear,
    output logic timeout
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear || ack || !req) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // An ack in the limit cycle wins over the timeout.
    assign timeout = req && !ack && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : FETCH/DECODE/EXEC/MEM/WB control FSM sharing one memory port.
//            Define PERF_CNT_EN to build the retire/busy-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        stop,
    input  logic        dec_rtype,
    input  logic        dec_imm,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_jump,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        alu_en,
    output logic        reg_we,
    output logic        reg_dst_sel,
    output logic        wb_src,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        busy,
    output logic        fault,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_retire;
    logic       w_timeout;
    logic       w_wait_req;
    logic [4:0] w_flags;

    assign w_flags    = {dec_jump, dec_store, dec_load, dec_imm, dec_rtype};
    assign w_wait_req = (r_state == FETCH) || (r_state == MEM);

    ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_ack_watchdog (
        .clk     (clk),
        .rst     (rst),
        .req     (w_wait_req),
        .ack     (mem_ack),
        .clear   (w_next_state != r_state),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel      = MEM_SEL_INSTR;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        alu_en       = 1'b0;
        reg_we       = 1'b0;
        reg_dst_sel  = DST_RD;
        wb_src       = WB_SRC_ALU;
        pc_we        = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        busy         = (r_state != IDLE) && (r_state != FAULT);
        fault        = (r_state == FAULT);

        case (r_state)
            IDLE: begin
                if (run) w_next_state = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
                if (mem_ack)        w_next_state = DECODE;
                else if (w_timeout) w_next_state = FAULT;
            end
            DECODE: begin
                if (!is_one_hot(w_flags)) begin
                    w_next_state = FAULT;
                end else if (dec_jump) begin
                    pc_we    = 1'b1;
                    pc_sel   = PC_SEL_JUMP;
                    w_retire = 1'b1;
                end else begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                alu_en       = 1'b1;
                w_next_state = (dec_load || dec_store) ? MEM : WB;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_sel = MEM_SEL_DATA;
                mem_we  = dec_store;
                if (mem_ack) begin
                    if (dec_load) begin
                        mdr_we       = 1'b1;
                        w_next_state = WB;
                    end else begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = FAULT;
                end
            end
            WB: begin
                reg_we      = 1'b1;
                reg_dst_sel = dec_rtype ? DST_RD : DST_RT;
                wb_src      = dec_load ? WB_SRC_MEM : WB_SRC_ALU;
                pc_we       = 1'b1;
                w_retire    = 1'b1;
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // stop is only honoured at an instruction boundary
        if (w_retire) w_next_state = stop ? IDLE : FETCH;
    end

`ifdef PERF_CNT_EN
    logic [31:0] r_instr_count;
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= 32'd0;
            r_cycle_count <= 32'd0;
        end else begin
            if (w_retire) r_instr_count <= r_instr_count + 32'd1;
            if (busy)     r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;
`else
    assign instr_count = 32'd0;
    assign cycle_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module   : tb_multicycle_sequencer
// Purpose  : Scoreboard bench; each instruction is expanded into its expected
//            per-cycle control schedule and compared against the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

    localparam int ACK_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    localparam logic [12:0] O_REQ   = 13'h1000;
    localparam logic [12:0] O_WE    = 13'h0800;
    localparam logic [12:0] O_SEL   = 13'h0400;
    localparam logic [12:0] O_IR    = 13'h0200;
    localparam logic [12:0] O_MDR   = 13'h0100;
    localparam logic [12:0] O_ALU   = 13'h0080;
    localparam logic [12:0] O_REGWE = 13'h0040;
    localparam logic [12:0] O_DST   = 13'h0020;
    localparam logic [12:0] O_WBS   = 13'h0010;
    localparam logic [12:0] O_PCWE  = 13'h0008;
    localparam logic [12:0] O_PCSEL = 13'h0004;
    localparam logic [12:0] O_BUSY  = 13'h0002;
    localparam logic [12:0] O_FLT   = 13'h0001;

    localparam int C_RTYPE = 0;
    localparam int C_IMM   = 1;
    localparam int C_LOAD  = 2;
    localparam int C_STORE = 3;
    localparam int C_JUMP  = 4;

    logic        clk = 1'b0;
    logic        rst, run, stop, mem_ack;
    logic [4:0]  flags;
    logic        mem_req, mem_we, mem_sel, ir_we, mdr_we, alu_en, reg_we;
    logic        reg_dst_sel, wb_src, pc_we, pc_sel, busy, fault;
    logic [31:0] instr_count, cycle_count;
    logic [12:0] act_outs;

    assign act_outs = {mem_req, mem_we, mem_sel, ir_we, mdr_we, alu_en, reg_we,
                       reg_dst_sel, wb_src, pc_we, pc_sel, busy, fault};

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .stop        (stop),
        .dec_rtype   (flags[0]),
        .dec_imm     (flags[1]),
        .dec_load    (flags[2]),
        .dec_store   (flags[3]),
        .dec_jump    (flags[4]),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .ir_we       (ir_we),
        .mdr_we      (mdr_we),
        .alu_en      (alu_en),
        .reg_we      (reg_we),
        .reg_dst_sel (reg_dst_sel),
        .wb_src      (wb_src),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .busy        (busy),
        .fault       (fault),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic [12:0] outs;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_ic;
    logic [31:0] m_cc;

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (act_outs !== e.outs) begin
                n_fail++;
                $display("FAIL outputs @%0t: got %013b expected %013b", $time, act_outs, e.outs);
            end
            n_checks++;
            if (instr_count !== e.ic || cycle_count !== e.cc) begin
                n_fail++;
                $display("FAIL counters @%0t: got instr=%0d cycle=%0d expected instr=%0d cycle=%0d",
                         $time, instr_count, cycle_count, e.ic, e.cc);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] junk();
        return 5'($urandom);
    endfunction

    // One clock cycle: drive inputs, record the expected outputs of the current state.
    task automatic step(input logic r, input logic rn, input logic sp, input logic ack,
                        input logic [4:0] f, input logic [12:0] outs, input bit retire);
        exp_t e;
        rst = r; run = rn; stop = sp; mem_ack = ack; flags = f;
        e.outs = outs;
`ifdef PERF_CNT_EN
        e.ic = m_ic;
        e.cc = m_cc;
`else
        e.ic = 32'd0;
        e.cc = 32'd0;
`endif
        sb_q.push_back(e);
        if (r) begin
            m_ic = 32'd0;
            m_cc = 32'd0;
        end else begin
            if ((outs & O_BUSY) != 13'd0) m_cc = m_cc + 32'd1;
            if (retire) m_ic = m_ic + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_raw();
        rst = 1'b1; run = 1'b0; stop = 1'b0; mem_ack = 1'b0; flags = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        m_ic = 32'd0;
        m_cc = 32'd0;
    endtask

    task automatic idle_then_run(input int n_idle);
        for (int i = 0; i < n_idle; i++) step(0, 0, rb(), rb(), junk(), 13'd0, 0);
        step(0, 1, rb(), rb(), junk(), 13'd0, 0);
    endtask

    // Expected schedule for one instruction starting in FETCH.
    task automatic do_instr(input int cls, input int df, input int dm, input bit stop_at);
        logic [4:0]  f;
        logic [12:0] base;
        f = 5'(1 << cls);
        for (int i = 0; i < df; i++) step(0, rb(), rb(), 0, junk(), O_REQ | O_BUSY, 0);
        step(0, rb(), rb(), 1, junk(), O_REQ | O_IR | O_BUSY, 0);
        if (cls == C_JUMP) begin
            step(0, rb(), stop_at, rb(), f, O_PCWE | O_PCSEL | O_BUSY, 1);
            return;
        end
        step(0, rb(), rb(), rb(), f, O_BUSY, 0);
        step(0, rb(), rb(), rb(), f, O_ALU | O_BUSY, 0);
        if (cls == C_LOAD || cls == C_STORE) begin
            base = O_REQ | O_SEL | O_BUSY | ((cls == C_STORE) ? O_WE : 13'd0);
            for (int i = 0; i < dm; i++) step(0, rb(), rb(), 0, f, base, 0);
            if (cls == C_STORE) begin
                step(0, rb(), stop_at, 1, f, base | O_PCWE, 1);
                return;
            end
            step(0, rb(), rb(), 1, f, base | O_MDR, 0);
        end
        step(0, rb(), stop_at, rb(), f,
             O_REGWE | O_PCWE | O_BUSY | ((cls == C_RTYPE) ? 13'd0 : O_DST) |
             ((cls == C_LOAD) ? O_WBS : 13'd0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit sp;
        reset_raw();
        step(0, 0, 0, 0, 5'd0, 13'd0, 0);

        // three back-to-back R-type with zero-wait ack, stop on the last
        step(0, 1, 0, 1, 5'd0, 13'd0, 0);
        do_instr(C_RTYPE, 0, 0, 0);
        do_instr(C_RTYPE, 0, 0, 0);
        do_instr(C_RTYPE, 0, 0, 1);
        idle_then_run(2);

        do_instr(C_LOAD, 0, 3, 0);
        do_instr(C_JUMP, 0, 0, 1);
        idle_then_run(1);
        do_instr(C_IMM, 3, 0, 0);
        do_instr(C_STORE, 1, 2, 0);

        for (int n = 0; n < 40; n++) begin
            sp = ($urandom_range(0, 4) == 0);
            do_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), sp);
            if (sp) idle_then_run($urandom_range(0, 2));
        end

        // fetch timeout, then sticky fault
        reset_raw();
        idle_then_run(0);
        for (int i = 0; i < ACK_TIMEOUT; i++) step(0, rb(), rb(), 0, junk(), O_REQ | O_BUSY, 0);
        for (int i = 0; i < 3; i++) step(0, rb(), rb(), rb(), junk(), O_FLT, 0);

        // data-phase timeout on a store
        reset_raw();
        idle_then_run(0);
        step(0, 0, 0, 1, 5'd0, O_REQ | O_IR | O_BUSY, 0);
        step(0, 0, 0, 0, 5'b01000, O_BUSY, 0);
        step(0, 0, 0, 0, 5'b01000, O_ALU | O_BUSY, 0);
        for (int i = 0; i < ACK_TIMEOUT; i++)
            step(0, 0, 0, 0, 5'b01000, O_REQ | O_SEL | O_WE | O_BUSY, 0);
        step(0, 1, 0, 1, 5'b01000, O_FLT, 0);

        // multiple class flags in decode
        reset_raw();
        idle_then_run(0);
        step(0, 0, 0, 1, 5'd0, O_REQ | O_IR | O_BUSY, 0);
        step(0, 0, 0, 0, 5'b01100, O_BUSY, 0);
        step(0, 1, 1, 1, 5'b01100, O_FLT, 0);
        step(0, 1, 0, 0, 5'b00001, O_FLT, 0);

        // no class flag in decode
        reset_raw();
        idle_then_run(0);
        step(0, 0, 0, 1, 5'd0, O_REQ | O_IR | O_BUSY, 0);
        step(0, 0, 0, 0, 5'b00000, O_BUSY, 0);
        step(0, 0, 0, 0, 5'b00001, O_FLT, 0);

        // reset in the middle of a load's data request
        reset_raw();
        idle_then_run(0);
        do_instr(C_RTYPE, 0, 0, 0);
        step(0, 0, 0, 1, 5'd0, O_REQ | O_IR | O_BUSY, 0);
        step(0, 0, 0, 0, 5'b00100, O_BUSY, 0);
        step(0, 0, 0, 0, 5'b00100, O_ALU | O_BUSY, 0);
        step(0, 0, 0, 0, 5'b00100, O_REQ | O_SEL | O_BUSY, 0);
        step(1, 0, 0, 0, 5'b00100, O_REQ | O_SEL | O_BUSY, 0);
        step(0, 0, 0, 1, 5'b00100, 13'd0, 0);
        step(0, 0, 0, 0, 5'd0, 13'd0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
